// File: rtl/fifo_drain.sv
// Dequeue-side adapter: pulls items from a FIFO head, hides its read latency behind a
// 2-entry skid buffer, and presents an in-order registered valid/ready stream.
module fifo_drain #(
  parameter int unsigned P_WIDTH     = 32,
  parameter int unsigned P_RD_LAT    = 1,
  parameter int unsigned P_CNT_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [P_WIDTH-1:0]     i_fifo_data,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_deq,
  output logic [P_WIDTH-1:0]     o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [P_CNT_WIDTH-1:0] o_count,
  output logic                   o_overflow
);

  logic [P_WIDTH-1:0]     buf0_q, buf0_d;
  logic [P_WIDTH-1:0]     buf1_q, buf1_d;
  logic [1:0]             occ_q, occ_d;
  logic                   infl_q, infl_d;
  logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic       pop;
  logic       cap;
  logic [1:0] occ_pop;
  logic [2:0] pending;

  assign o_valid = (occ_q != 2'd0);
  assign pop     = o_valid & i_ready;

  // Slots already claimed once this edge's pop is accounted for; pop implies occ_q >= 1.
  assign pending    = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign o_fifo_deq = !i_rst && !i_fifo_empty && (pending < 3'd2);

  // Zero-latency FIFOs hand over data in the deq cycle; otherwise one cycle later.
  assign cap    = (P_RD_LAT == 0) ? o_fifo_deq : infl_q;
  assign infl_d = (P_RD_LAT != 0) && o_fifo_deq;

  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q + P_CNT_WIDTH'(pop);
    occ_pop = occ_q - {1'b0, pop};
    occ_d   = occ_pop;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (cap) begin
      case (occ_pop)
        2'd0: begin
          buf0_d = i_fifo_data;
          occ_d  = 2'd1;
        end
        2'd1: begin
          buf1_d = i_fifo_data;
          occ_d  = 2'd2;
        end
        default: begin
          ovf_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      buf0_q <= '0;
      buf1_q <= '0;
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      occ_q  <= occ_d;
      infl_q <= infl_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_data     = buf0_q;
  assign o_count    = cnt_q;
  assign o_overflow = ovf_q;

endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Dequeue-side adapter for the team's IFIFO/FIFO buffers. It sits between a FIFO's head (data/empty/deq) and a downstream merge or compare stage that uses valid/ready.
- It issues FIFO dequeues, absorbs the FIFO's read latency with an internal 2-entry skid buffer, and presents an in-order registered valid/ready stream.
- It sustains 1 item/cycle under continuous ready.

Parameters:
- P_WIDTH, 32, data width in bits.
- P_RD_LAT, 1, FIFO read latency: 0 = first-word-fall-through (head data valid while !empty); 1 = data valid the cycle after deq. Only 0 and 1 are legal.
- P_CNT_WIDTH, 32, width of delivered-item counter.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  synchronous reset, active-high.
- i_fifo_data  in  P_WIDTH  FIFO head data.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_deq  out  1  dequeue strobe to FIFO (combinational).
- o_data  out  P_WIDTH  output item (registered, buffer head).
- o_valid  out  1  o_data holds a valid item.
- i_ready  in  1  downstream accepts o_data this cycle.
- o_count  out  P_CNT_WIDTH  items delivered (o_valid & i_ready) since reset; wraps modulo 2^P_CNT_WIDTH.
- o_overflow  out  1  sticky error: returned data found no free buffer slot.

Behaviour:
- Reset (i_rst=1 at posedge):
  - occupancy = 0, inflight = 0, o_valid = 0, o_count = 0, o_overflow = 0; o_data = 0.
  - o_fifo_deq = 0 combinationally while i_rst = 1.
- Buffer:
  - 2 entries, FIFO order. Entry 0 drives o_data/o_valid directly.
  - On pop (o_valid & i_ready), entry 1 shifts to entry 0 in the same edge.
- Transfer: o_valid & i_ready at posedge delivers one item and increments o_count by 1.
- Dequeue rule (combinational):
  - o_fifo_deq = !i_rst & !i_fifo_empty & (occupancy + inflight − pop < 2), where pop = o_valid & i_ready.
  - Dequeue in the same cycle as a pop is allowed; this gives full throughput.
  - o_fifo_deq is never asserted while i_fifo_empty = 1.
- P_RD_LAT = 0:
  - i_fifo_data is written into the buffer at the posedge where o_fifo_deq = 1.
  - inflight is always 0.
- P_RD_LAT = 1:
  - inflight is set to 1 at a posedge with o_fifo_deq = 1, else cleared.
  - i_fifo_data is captured at the posedge one cycle after the deq cycle.
  - Write slot = occupancy after this edge's pop.
- Invariant: occupancy + inflight ≤ 2.
- Simultaneous pop and write:
  - occupancy is unchanged.
  - The new item goes behind the remaining item, or into entry 0 if the buffer is now empty.
- Latency, empty drain to first o_valid:
  - P_RD_LAT = 0: o_valid rises 1 cycle after the deq cycle.
  - P_RD_LAT = 1: o_valid rises 2 cycles after the deq cycle.
- Back-pressure:
  - With i_ready = 0, at most 2 items are buffered, and deq stops once occupancy + inflight = 2.
  - o_data/o_valid hold stable while i_ready = 0.
- Overflow:
  - If a capture occurs with occupancy = 2 after pop, the item is dropped and o_overflow is set.
  - o_overflow stays set until reset. This is unreachable in correct operation; verification checks it stays 0.
- Reset mid-operation:
  - Data returning the cycle after a deq is discarded if i_rst = 1 on that edge.
  - inflight is cleared, so no phantom capture occurs after reset deasserts.
- Counter wrap: o_count rolls over to 0 after 2^P_CNT_WIDTH − 1 with no flag.

Test Plan:
1. Single item, P_RD_LAT = 1: FIFO holds 0xA5A5_0001 with i_ready = 1.
   - Cycle t: o_fifo_deq = 1.
   - Cycle t+2: o_valid = 1 with o_data = 0xA5A5_0001.
   - Next edge: o_count = 1; o_valid drops, and o_fifo_deq stays 0 while empty.
2. Streaming: FIFO supplies 0..15 continuously with i_ready = 1 (both P_RD_LAT values).
   - o_fifo_deq is high 16 consecutive cycles.
   - Outputs are 0..15 in order, 1 per cycle after the initial latency.
   - o_count = 16; o_overflow = 0.
3. Back-pressure: 10 items queued, i_ready = 0 for 8 cycles, then 1.
   - Exactly 2 deqs are issued, then deq stays low and o_data holds item 0.
   - After release, items 0..9 are delivered in order with no gaps once steady.
4. Toggle ready: i_ready pattern 1,0,1,0… over 12 items.
   - No item is lost or duplicated; the output sequence matches input.
   - occupancy + inflight never exceeds 2; o_overflow = 0.
5. Reset mid-flight, P_RD_LAT = 1: deq at cycle t, i_rst = 1 at cycle t+1.
   - The returned data is discarded; o_valid = 0 and o_count = 0 after reset.
   - The next dequeued item (e.g. 0x0000_0042) is delivered as the first output.
6. Wrap, P_CNT_WIDTH = 4: deliver 17 items.
   - o_count reads 15 after 15 items, 0 after 16, and 1 after 17.
